// File: rtl/mem_initiator_if.sv
// Request/response and memory-strobe bundle for mem_initiator.
// req_valid/req_ready: a request transfers on a rising edge where both are 1; rsp_valid is a one-cycle pulse.
interface mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_data, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_fault,
           mem_read, mem_write, mem_addr, mem_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_data, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_fault,
           mem_read, mem_write, mem_addr, mem_data
  );
endinterface

// File: rtl/mem_initiator.sv
// Bus master for a single-port synchronous word memory: one outstanding load/store at a time.
// Define MEM_ALIGN_CHECK_EN to fault requests whose byte address is not word aligned.
module mem_initiator #(
  parameter int READ_LATENCY = 1,
  parameter int MEM_WORDS    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  mem_initiator_if.master  bus,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [3:0]  LAT_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [31:0] WORDS    = 32'(MEM_WORDS);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        accept, range_fault, align_fault, req_fault;
  logic        req_ready_d, rsp_valid_d, rsp_fault_d, mem_read_d, mem_write_d;
  logic [31:0] rsp_data_d, mem_addr_d, mem_data_d;

  assign accept      = bus.req_valid && bus.req_ready;
  // Full 30-bit word index compare so high address bits can never alias into range.
  assign range_fault = {2'b00, bus.req_addr[31:2]} >= WORDS;
`ifdef MEM_ALIGN_CHECK_EN
  assign align_fault = |bus.req_addr[1:0];
`else
  assign align_fault = 1'b0;
`endif
  assign req_fault   = range_fault || align_fault;
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_fault <= 1'b0;
      bus.rsp_data  <= 32'd0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_data  <= 32'd0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      bus.req_ready <= req_ready_d;
      bus.rsp_valid <= rsp_valid_d;
      bus.rsp_fault <= rsp_fault_d;
      bus.rsp_data  <= rsp_data_d;
      bus.mem_read  <= mem_read_d;
      bus.mem_write <= mem_write_d;
      bus.mem_addr  <= mem_addr_d;
      bus.mem_data  <= mem_data_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_fault) begin
            state_d = RESP;
          end else if (bus.req_write) begin
            state_d = WR;
          end else begin
            state_d = RD;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      RD: begin
        if (cnt == 4'd0) state_d = CAP;
        else             cnt_d   = cnt - 4'd1;
      end
      CAP:     state_d = RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    mem_read_d  = (state_d == RD);
    mem_write_d = (state_d == WR);
    rsp_valid_d = (state_d == RESP);
    rsp_fault_d = (state == IDLE) && accept && req_fault;
    mem_addr_d  = bus.mem_addr;
    mem_data_d  = bus.mem_data;
    rsp_data_d  = bus.rsp_data;
    if (state == IDLE && accept) begin
      mem_addr_d = bus.req_addr;
      mem_data_d = bus.req_data;
    end
    if (state == CAP) begin
      rsp_data_d = bus.mem_rdata;
    end else if (state_d == RESP) begin
      rsp_data_d = 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: two instances (read latency 1 and 3) share stimulus, each with its own memory model.
module tb_mem_initiator;

  localparam int LAT_A     = 1;
  localparam int LAT_B     = 3;
  localparam int MEM_WORDS = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_initiator_if bus_a();
  mem_initiator_if bus_b();
  logic [2:0] state_a, state_b;

  mem_initiator #(.READ_LATENCY(LAT_A), .MEM_WORDS(MEM_WORDS)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(state_a)
  );
  mem_initiator #(.READ_LATENCY(LAT_B), .MEM_WORDS(MEM_WORDS)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(state_b)
  );

  // ---------------- memory models ----------------
  logic [31:0] mem_a [0:MEM_WORDS-1];
  logic [31:0] mem_b [0:MEM_WORDS-1];
  int          rd_cnt_a, rd_cnt_b;
  logic        mem_clr, poke_en;
  int          poke_word;
  logic [31:0] poke_val;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_a[i] <= 32'd0;
        mem_b[i] <= 32'd0;
      end
    end else begin
      if (poke_en) begin
        mem_a[poke_word] <= poke_val;
        mem_b[poke_word] <= poke_val;
      end
      if (bus_a.mem_write) mem_a[bus_a.mem_addr[11:2]] <= bus_a.mem_data;
      if (bus_b.mem_write) mem_b[bus_b.mem_addr[11:2]] <= bus_b.mem_data;
    end
    rd_cnt_a <= bus_a.mem_read ? rd_cnt_a + 1 : 0;
    rd_cnt_b <= bus_b.mem_read ? rd_cnt_b + 1 : 0;
  end

  // Read data is only valid exactly READ_LATENCY cycles after the address was first presented.
  assign bus_a.mem_rdata = (rd_cnt_a == LAT_A) ? mem_a[bus_a.mem_addr[11:2]] : 32'hBAD0_BAD0;
  assign bus_b.mem_rdata = (rd_cnt_b == LAT_B) ? mem_b[bus_b.mem_addr[11:2]] : 32'hBAD0_BAD0;

  // ---------------- reference state ----------------
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  logic [31:0] last_rsp [2];
  int          checks, errors;
  string       nm [8] = '{"mem_read", "mem_write", "rsp_valid", "req_ready",
                          "rsp_fault", "rsp_data", "mem_addr", "mem_data"};

  function automatic logic exp_fault(input logic [31:0] a);
    logic f;
    f = (a / 4) >= MEM_WORDS;
`ifdef MEM_ALIGN_CHECK_EN
    if (a % 4 != 0) f = 1'b1;
`endif
    return f;
  endfunction

  function automatic logic [7:0][31:0] sample(input int k);
    logic [7:0][31:0] o;
    o[0] = 32'(k == 0 ? bus_a.mem_read  : bus_b.mem_read);
    o[1] = 32'(k == 0 ? bus_a.mem_write : bus_b.mem_write);
    o[2] = 32'(k == 0 ? bus_a.rsp_valid : bus_b.rsp_valid);
    o[3] = 32'(k == 0 ? bus_a.req_ready : bus_b.req_ready);
    o[4] = 32'(k == 0 ? bus_a.rsp_fault : bus_b.rsp_fault);
    o[5] = (k == 0) ? bus_a.rsp_data : bus_b.rsp_data;
    o[6] = (k == 0) ? bus_a.mem_addr : bus_b.mem_addr;
    o[7] = (k == 0) ? bus_a.mem_data : bus_b.mem_data;
    return o;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_req(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = a; bus_a.req_data = d;
    bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_addr = a; bus_b.req_data = d;
  endtask

  task automatic poke(input int word, input logic [31:0] val);
    poke_en = 1'b1; poke_word = word; poke_val = val;
    ref_mem[word] = val;
    @(posedge clk); #1 poke_en = 1'b0;
    @(negedge clk);
  endtask

  // One transaction; every cycle of both instances is compared against the latency rules.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic f;
    logic [31:0] exp_data;
    int lat, rsp_at, tmo;
    logic [7:0][31:0] obs, expv;
    logic [7:0] en;
    f = exp_fault(addr);
    exp_data = (wr || f) ? 32'd0 : ref_mem[addr[11:2]];
    tmo = 0;
    while (!(bus_a.req_ready && bus_b.req_ready) && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    checks++;
    if (tmo >= 20) begin
      errors++;
      $display("FAIL ready_timeout got 0 exp 1");
    end
    drive_req(1'b1, wr, addr, data);
    @(posedge clk); #1 drive_req(1'b0, 1'($urandom), $urandom, $urandom);
    for (int cyc = 1; cyc <= LAT_B + 3; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        lat    = (k == 0) ? LAT_A : LAT_B;
        rsp_at = f ? 1 : (wr ? 2 : lat + 2);
        obs    = sample(k);
        expv[0] = 32'(!f && !wr && cyc <= lat);
        expv[1] = 32'(!f && wr && cyc == 1);
        expv[2] = 32'(cyc == rsp_at);
        expv[3] = 32'(cyc > rsp_at);
        expv[4] = 32'(f && cyc == rsp_at);
        expv[5] = (cyc >= rsp_at) ? exp_data : last_rsp[k];
        expv[6] = addr;
        expv[7] = data;
        en = 8'h3F;
        en[6] = !f && cyc < rsp_at;
        en[7] = !f && wr && cyc == 1;
        for (int i = 0; i < 8; i++) begin
          if (en[i]) begin
            checks++;
            if (obs[i] !== expv[i]) begin
              errors++;
              $display("FAIL txn_%s dut%0d addr %h cyc %0d got %h exp %h", nm[i], k, addr, cyc, obs[i], expv[i]);
            end
          end
        end
      end
    end
    if (wr && !f) ref_mem[addr[11:2]] = data;
    last_rsp[0] = exp_data;
    last_rsp[1] = exp_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0][31:0] obs, expv;
    @(negedge clk);
    expv = '0;
    expv[3] = 32'd1;
    for (int k = 0; k < 2; k++) begin
      obs = sample(k);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs[i] !== expv[i]) begin
          errors++;
          $display("FAIL reset_%s dut%0d got %h exp %h", nm[i], k, obs[i], expv[i]);
        end
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    last_rsp[0] = 32'd0;
    last_rsp[1] = 32'd0;
  endtask

  task automatic test_store_load();
    do_txn(1'b1, 32'h10, 32'hDEAD_BEEF);
    do_txn(1'b0, 32'h10, 32'h0);
    do_txn(1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_fault();
    do_txn(1'b0, 32'h1000, 32'h0);
    do_txn(1'b0, 32'hFFC, 32'h0);
    do_txn(1'b1, 32'h1000, 32'hCAFE_F00D);
    do_txn(1'b0, 32'hFFFF_FFF0, 32'h0);
    do_txn(1'b0, 32'h0010_0010, 32'h0);
    do_txn(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_align();
    do_txn(1'b0, 32'h12, 32'h0);
    do_txn(1'b1, 32'h13, $urandom);
    do_txn(1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    logic [7:0][31:0] obs, expv;
    logic [7:0] en;
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    for (int cyc = 0; cyc <= 9; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        obs = sample(k);
        expv[0] = 32'd0;
        expv[1] = 32'(cyc % 3 == 1);
        expv[2] = 32'(cyc % 3 == 2);
        expv[3] = 32'(cyc % 3 == 0);
        expv[4] = 32'd0;
        expv[5] = (cyc >= 2) ? 32'd0 : last_rsp[k];
        expv[6] = 32'(4 * (cyc / 3));
        expv[7] = (cyc % 3 == 1) ? d[cyc / 3] : 32'd0;
        en = 8'h3F;
        en[6] = (cyc % 3 == 1);
        en[7] = (cyc % 3 == 1);
        for (int i = 0; i < 8; i++) begin
          if (en[i]) begin
            checks++;
            if (obs[i] !== expv[i]) begin
              errors++;
              $display("FAIL b2b_%s dut%0d cyc %0d got %h exp %h", nm[i], k, cyc, obs[i], expv[i]);
            end
          end
        end
      end
      if (cyc % 3 == 0 && cyc < 9) drive_req(1'b1, 1'b1, 32'(4 * (cyc / 3)), d[cyc / 3]);
      else if (cyc < 9)            drive_req(1'b1, 1'($urandom), $urandom, $urandom);
      else                         drive_req(1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) ref_mem[i] = d[i];
    last_rsp[0] = 32'd0;
    last_rsp[1] = 32'd0;
    for (int i = 0; i < 3; i++) do_txn(1'b0, 32'(4 * i), 32'h0);
  endtask

  task automatic test_reset_mid_read();
    logic [7:0][31:0] obs, expv;
    drive_req(1'b1, 1'b0, 32'h20, 32'h0);
    @(posedge clk); #1 drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    expv = '0;
    expv[3] = 32'd1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        obs = sample(k);
        for (int i = 0; i < 6; i++) begin
          checks++;
          if (obs[i] !== expv[i]) begin
            errors++;
            $display("FAIL rstmid_%s dut%0d cyc %0d got %h exp %h", nm[i], k, cyc, obs[i], expv[i]);
          end
        end
      end
    end
    last_rsp[0] = 32'd0;
    last_rsp[1] = 32'd0;
    do_txn(1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
      else a = 32'($urandom_range(0, MEM_WORDS - 1) * 4) |
               (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
      do_txn(1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'd0;
    rst = 1'b1;
    mem_clr = 1'b1;
    poke_en = 1'b0;
    poke_word = 0;
    poke_val = 32'd0;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    test_reset();
    poke(8, 32'h1234_5678);
    poke(MEM_WORDS - 1, $urandom);
    test_store_load();
    test_fault();
    test_align();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Bus-master side of the single-port synchronous word memory.
- Accepts load/store requests from the processor datapath (MAR/MDR path) over a valid/ready handshake.
- Drives the memory's read/write strobes, address and write data, and waits out the memory's registered read latency.
- Returns the captured read data, or a completion pulse for writes, with a fault flag for illegal addresses.

Parameters:
- READ_LATENCY, 1, cycles from address presented to iMemData valid (legal range 1..15).
- MEM_WORDS, 1024, number of 32-bit words in the target memory; word index >= MEM_WORDS faults.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  reset; synchronous, active-high.
- iReqValid  in  1  request present.
- oReqReady  out  1  controller can accept a request.
- iReqWrite  in  1  1 = store, 0 = load.
- iReqAddr  in  32  byte address.
- iReqData  in  32  store data.
- oRspValid  out  1  one-cycle completion pulse.
- oRspData  out  32  load data; 0 for stores and faults.
- oRspFault  out  1  qualifies oRspValid; request rejected.
- oMemRead  out  1  memory read strobe.
- oMemWrite  out  1  memory write strobe.
- oMemAddr  out  32  memory byte address.
- oMemData  out  32  memory write data.
- iMemData  in  32  memory registered read data.

Behaviour:
- All outputs are registered.
- Reset values: oReqReady=1; oRspValid=0; oRspFault=0; oRspData=0; oMemRead=0; oMemWrite=0; oMemAddr=0; oMemData=0; state IDLE; latency counter 0.
- Request acceptance: a request is accepted on an edge where iReqValid && oReqReady. At that edge iReqWrite, iReqAddr and iReqData are latched.
- oReqReady is 1 only in IDLE. One request is outstanding at most.
- FSM states: IDLE, RD, CAP, WR, RESP.
- IDLE:
  - Accepted request with an illegal address goes to RESP with the fault flag set; no strobe is ever asserted.
  - Legal store goes to WR; legal load goes to RD.
  - oMemAddr/oMemData are loaded with the latched values on the same edge.
- RD: oMemRead=1 and oMemAddr stable for exactly READ_LATENCY cycles, counted by a 4-bit down-counter, then go to CAP.
- CAP: oMemRead=0, oMemAddr held. iMemData is sampled into oRspData at the end of this cycle. Go to RESP.
- WR: oMemWrite=1 for exactly one cycle, with oMemAddr and oMemData stable. Go to RESP.
- RESP: oRspValid=1 for one cycle. oRspFault is valid in this cycle and cleared on exit. Go to IDLE.
- Response holding: oRspData holds its value until the next RESP. Stores and faults drive it to 0.
- Latency (request accepted at end of cycle 0):
  - Load: oMemRead in cycles 1..READ_LATENCY, CAP in cycle READ_LATENCY+1, oRspValid in cycle READ_LATENCY+2.
  - Store: oMemWrite in cycle 1, oRspValid in cycle 2.
  - Fault: oRspValid in cycle 1.
- Next request is accepted no earlier than the cycle after RESP.
- Address legality: word index = iReqAddr[31:2]. The address is illegal if the word index >= MEM_WORDS, compared at full 30-bit width with no truncation.
- oMemRead and oMemWrite are never asserted together.
- iReqValid is ignored outside IDLE, and request inputs may change freely outside IDLE.
- Reset mid-operation: at the next edge all strobes drop to 0 and the FSM returns to IDLE. The in-flight transaction is abandoned with no oRspValid; a write in WR during the reset edge is cancelled.
- iRst has priority over every transition, including acceptance on the same edge.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: an accepted request with iReqAddr[1:0] != 0 is a fault. It goes IDLE to RESP with oRspFault=1, no strobe, and oRspData=0. Range faults are still checked.
- Undefined: iReqAddr[1:0] is forwarded unchanged on oMemAddr and never faults; the memory ignores the low two bits.

Test Plan:
- Store then load, READ_LATENCY=1:
  - Store addr 0x10, data 0xDEADBEEF -> oMemWrite high only in cycle 1, oRspValid in cycle 2, oRspData=0.
  - Load 0x10 -> oMemRead in cycle 1, oRspValid in cycle 3 with oRspData=0xDEADBEEF, oRspFault=0.
- READ_LATENCY=3, load of preloaded word 0x12345678 at 0x20 -> oMemRead high exactly cycles 1-3, oRspValid in cycle 5 with data 0x12345678; oReqReady=0 in cycles 1-5.
- Load 0x1000 (word 1024, MEM_WORDS=1024) -> no strobe, oRspValid and oRspFault in cycle 1, oRspData=0. Load 0xFFC (word 1023) -> succeeds.
- iReqValid held high across back-to-back stores to 0x0, 0x4, 0x8 -> three oMemWrite pulses, each followed by oRspValid; each accept occurs only in IDLE; no overlap of strobes.
- iRst asserted in the second RD cycle (READ_LATENCY=3) -> next edge oMemRead=0, oReqReady=1, no oRspValid ever; a following load completes normally.
- Load 0x12: with MEM_ALIGN_CHECK_EN -> fault in cycle 1, no strobe; without the macro -> oMemAddr=0x12 and returns the word at 0x10.
